mxu: RTL and testbench
======================

MXU -- requirements
Module: mxu

Interface
REQ-001 SHALL have parameter SIZE, default 4, the matrix dimension (SIZE x SIZE operands); legal range 2..8.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have port wdata, input, 8 bits, the write data.
REQ-005 SHALL have port awaddr, input, 32 bits, the write word address.
REQ-006 SHALL have port wready, input, 1 bit, the write strobe; a write occurs on each rising edge where it is high.
REQ-007 SHALL have port araddr, input, 32 bits, the read word address.
REQ-008 SHALL have port arready, input, 1 bit, the read strobe; a read occurs on each rising edge where it is high.
REQ-009 SHALL have port rdata, output, 32 bits, the registered read data.

Function
REQ-010 SHALL decode write addresses as follows:
- 0: control; wdata[0]=1 starts a multiply.
- 1: cycle-count register N, 8 bits.
- 2 .. 1+SIZE*SIZE: matrix A, row-major; A[i][j] at 2+i*SIZE+j.
- 2+SIZE*SIZE .. 1+2*SIZE*SIZE: matrix B, row-major.
- All other addresses: ignored.
REQ-011 SHALL treat operands as 8-bit unsigned and accumulators as 32-bit unsigned (wrap on overflow).
REQ-012 SHALL use states IDLE, RUN and DONE. IDLE/DONE -> RUN on a start write; RUN -> DONE after exactly N clock cycles; N=0 goes directly to DONE.
REQ-013 SHALL clear all SIZE*SIZE accumulators and the step counter on the start edge.
REQ-014 SHALL operate as an output-stationary systolic array during RUN. At step t (0..N-1), PE(i,j) adds A[i][k]*B[k][j] with k=t-i-j, only when 0<=k<SIZE.
REQ-015 SHALL therefore hold the full product C=A*B once N>=3*SIZE-2; a smaller N leaves partial sums exactly as defined by REQ-014.
REQ-016 SHALL ignore writes to the A, B, count and control addresses while in RUN.
REQ-017 SHALL decode read addresses as follows:
- 0: status; bit0 = busy (RUN), bit1 = done (DONE), other bits 0.
- 1+r*SIZE+c (0<=r,c<SIZE): C[r][c].
- All other addresses: 0.
REQ-018 SHALL update rdata on the rising edge where arready=1 and hold it until the next read; the value is visible one cycle after the strobe.
REQ-019 SHALL keep accumulators unchanged in DONE until the next start; reads SHALL be legal in any state.
REQ-020 SHALL NOT read back A, B or N; they retain their values across multiplies.

Reset
REQ-021 SHALL on reset=0 immediately clear:
- the state to IDLE;
- rdata, N, A, B, all accumulators and the step counter to 0.
REQ-022 SHALL abort a RUN in progress when reset is asserted, with no partial result retained.

Verification
REQ-023 Reset: assert reset=0 mid-RUN -> read addr 0 returns 0, every C read returns 0.
REQ-024 Full multiply: load A=[[5,2,6,1],[0,6,2,0],[3,8,1,4],[1,8,5,6]], B=[[7,5,8,0],[1,8,2,6],[9,4,3,8],[5,3,7,9]] at addrs 2..33; write N=20 to addr 1; write 1 to addr 0; wait 65 cycles -> reads of addrs 1..16 return 96,68,69,69, 24,56,18,52, 58,95,71,92, 90,107,81,142.
REQ-025 Status: after the start write, addr 0 reads 1 (busy) during RUN, then 2 (done) after N cycles; N=0 gives 2 immediately.
REQ-026 Partial: same operands with N=1 -> C[0][0]=35 (5*7), all other C entries 0.
REQ-027 Overflow/width: all A and B entries 255, N=10 -> every C entry reads 260100; out-of-range read (addr 40) returns 0.
REQ-028 Write lock: write A during RUN -> ignored; the result equals that of the original operands.

Source files
------------

// File: rtl/mxu.sv
// SIZE x SIZE output-stationary matrix multiply unit with a simple register-mapped write/read port.
// Latency: a run lasts N cycles after the start write; rdata is valid one cycle after the read strobe.
// Backpressure: none; every strobe is accepted. Writes to A, B, N and control are dropped while busy.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-low reset
//   wdata/awaddr/wready - write data, word address and strobe (one write per strobed edge)
//   araddr/arready      - read word address and strobe
//   rdata               - registered read data, held until the next read
module mxu #(
    parameter int SIZE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  wdata,
    input  logic [31:0] awaddr,
    input  logic        wready,
    input  logic [31:0] araddr,
    input  logic        arready,
    output logic [31:0] rdata
);

    localparam int NE     = SIZE * SIZE;
    localparam int A_BASE = 2;
    localparam int B_BASE = 2 + NE;
    localparam int C_BASE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  a_mem [NE];
    logic [7:0]  b_mem [NE];
    logic [31:0] acc   [NE];
    logic [15:0] term  [NE];
    logic [7:0]  n_reg;
    logic [7:0]  step;

    logic        busy;
    logic        done;
    logic        acc_en;
    logic        wr_en;
    logic        start;
    logic [31:0] rd_val;

    // Register-file writes are only honoured outside RUN, so operands and
    // the cycle count cannot change under an active multiply.
    assign wr_en = wready && (state != RUN);
    assign start = wr_en && (awaddr == 32'd0) && wdata[0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    // A zero-length run has nothing to accumulate.
                    state_nxt = (n_reg == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                // n_reg is at least 1 here: a zero count never enters RUN
                // and the count register is locked while running.
                if (step == n_reg - 8'd1) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (state == RUN);
        done   = (state == DONE);
        acc_en = (state == RUN);
    end

    // ------------------------------------------------------------------
    // Operand and count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_reg <= '0;
            for (int e = 0; e < NE; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
            end
        end else if (wr_en) begin
            if (awaddr == 32'd1) begin
                n_reg <= wdata;
            end
            for (int e = 0; e < NE; e++) begin
                if (awaddr == 32'(A_BASE + e)) begin
                    a_mem[e] <= wdata;
                end
                if (awaddr == 32'(B_BASE + e)) begin
                    b_mem[e] <= wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Step counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step <= '0;
        end else if (start) begin
            step <= '0;
        end else if (acc_en) begin
            step <= step + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Systolic wavefront: A streams in skewed by row and B by column, so
    // PE(i,j) meets the pair A[i][k], B[k][j] at step t = i + j + k. The
    // pair is selected directly by step index rather than through shift
    // registers, which gives the same per-step contribution.
    // ------------------------------------------------------------------
    always_comb begin
        for (int e = 0; e < NE; e++) begin
            term[e] = '0;
        end
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                for (int k = 0; k < SIZE; k++) begin
                    if (int'(step) == i + j + k) begin
                        term[i*SIZE+j] = 16'(a_mem[i*SIZE+k]) * 16'(b_mem[k*SIZE+j]);
                    end
                end
            end
        end
    end

    // Accumulators wrap at 32 bits; they hold in IDLE and DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < NE; e++) begin
                acc[e] <= '0;
            end
        end else if (start) begin
            for (int e = 0; e < NE; e++) begin
                acc[e] <= '0;
            end
        end else if (acc_en) begin
            for (int e = 0; e < NE; e++) begin
                acc[e] <= acc[e] + 32'(term[e]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: status at 0, C row-major from 1, everything else 0.
    // ------------------------------------------------------------------
    always_comb begin
        rd_val = '0;
        if (araddr == 32'd0) begin
            rd_val = {30'd0, done, busy};
        end
        for (int e = 0; e < NE; e++) begin
            if (araddr == 32'(C_BASE + e)) begin
                rd_val = acc[e];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (arready) begin
            rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_mxu.sv
module tb_mxu;

    logic        clk;
    logic        reset;
    logic [7:0]  wdata;
    logic [31:0] awaddr;
    logic        wready;
    logic [31:0] araddr;
    logic        arready;
    logic [31:0] rdata;

    int checks;
    int errors;

    logic [31:0] exp_q  [$];
    string       name_q [$];
    logic        rd_vld;

    int a_init [16] = '{5,2,6,1, 0,6,2,0, 3,8,1,4, 1,8,5,6};
    int b_init [16] = '{7,5,8,0, 1,8,2,6, 9,4,3,8, 5,3,7,9};
    int c_full [16] = '{96,68,69,69, 24,56,18,52, 58,95,71,92, 90,107,81,142};

    mxu #(.SIZE(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .wdata   (wdata),
        .awaddr  (awaddr),
        .wready  (wready),
        .araddr  (araddr),
        .arready (arready),
        .rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A read strobed on a rising edge presents its data from that edge on.
    always @(posedge clk or negedge reset) begin
        if (!reset) rd_vld <= 1'b0;
        else        rd_vld <= arready;
    end

    // Monitor: pops one expectation per presented read.
    always @(negedge clk) begin
        if (rd_vld) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_read: got %0d, nothing expected", rdata);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rdata !== e) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %0d expected %0d", n, rdata, e);
                end
            end
        end
    end

    task automatic wr(input int addr, input int data);
        awaddr = 32'(addr);
        wdata  = 8'(data);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [31:0] exp, input string name);
        araddr  = 32'(addr);
        arready = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        arready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_ab(input int a [16], input int b [16]);
        for (int e = 0; e < 16; e++) wr(2 + e, a[e]);
        for (int e = 0; e < 16; e++) wr(18 + e, b[e]);
    endtask

    initial begin
        int all255 [16];
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        wdata   = '0;
        awaddr  = '0;
        wready  = 1'b0;
        araddr  = '0;
        arready = 1'b0;
        for (int e = 0; e < 16; e++) all255[e] = 255;

        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state
        rd(0, 32'd0, "rst_status");
        rd(1, 32'd0, "rst_c00");

        // Full multiply
        load_ab(a_init, b_init);
        wr(1, 20);
        wr(0, 1);
        idle(65);
        for (int e = 0; e < 16; e++) rd(1 + e, 32'(c_full[e]), $sformatf("full_c%0d", e));
        rd(0, 32'd2, "full_status_done");

        // Status timing with N=5: busy on the five strobes after start, done on the sixth
        wr(1, 5);
        wr(0, 1);
        for (int t = 0; t < 5; t++) rd(0, 32'd1, $sformatf("n5_busy_%0d", t));
        rd(0, 32'd2, "n5_done");

        // N=0 goes straight to DONE and still clears accumulators
        wr(1, 0);
        wr(0, 1);
        rd(0, 32'd2, "n0_done");
        rd(1, 32'd0, "n0_c00_cleared");

        // Partial: N=1 gives only PE(0,0)'s first term
        wr(1, 1);
        wr(0, 1);
        idle(3);
        for (int e = 0; e < 16; e++)
            rd(1 + e, (e == 0) ? 32'd35 : 32'd0, $sformatf("part_c%0d", e));

        // Write lock: operand, count and control writes during RUN are dropped
        wr(1, 20);
        wr(0, 1);
        wr(2, 100);
        wr(1, 1);
        wr(0, 1);
        rd(0, 32'd1, "lock_busy");
        idle(30);
        for (int e = 0; e < 16; e++) rd(1 + e, 32'(c_full[e]), $sformatf("lock_c%0d", e));

        // Overflow/width: all 255, N=10 is exactly the full wavefront
        load_ab(all255, all255);
        wr(1, 10);
        wr(0, 1);
        idle(12);
        for (int e = 0; e < 16; e++) rd(1 + e, 32'd260100, $sformatf("ovf_c%0d", e));
        rd(40, 32'd0, "oor_addr40");
        rd(17, 32'd0, "oor_addr17");

        // Reset mid-RUN
        load_ab(a_init, b_init);
        wr(1, 20);
        wr(0, 1);
        rd(0, 32'd1, "pre_rst_busy");
        idle(4);
        #2;
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        rd(0, 32'd0, "mid_rst_status");
        for (int e = 0; e < 16; e++) rd(1 + e, 32'd0, $sformatf("mid_rst_c%0d", e));

        idle(3);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
